// File: rtl/seg7_scan_reader.sv
// Recovers per-digit hex nibbles from a multiplexed active-low 7-segment bus.
// Synchronises, debounces each scan slot, decodes and publishes complete frames.
module seg7_scan_reader #(
  parameter int N_DIG      = 4,
  parameter int STABLE_CYC = 16
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic [6:0]         SEG,
  input  logic [N_DIG-1:0]   DIG_SEL,
  output logic [4*N_DIG-1:0] HEX_OUT,
  output logic [N_DIG-1:0]   SEG_ERR,
  output logic               FRAME_VALID
);

  localparam int SW = N_DIG + 7;
  localparam int CW = $clog2(STABLE_CYC + 2);
  localparam logic [CW-1:0] C_CAP = CW'(STABLE_CYC);
  localparam logic [CW-1:0] C_SAT = CW'(STABLE_CYC + 1);

  logic [SW-1:0]      r_sync1;
  logic [SW-1:0]      r_sync2;
  logic [CW-1:0]      r_cnt;
  logic [4*N_DIG-1:0] r_slot_hex;
  logic [N_DIG-1:0]   r_slot_err;
  logic [N_DIG-1:0]   r_mask;
  logic [4*N_DIG-1:0] r_hex_out;
  logic [N_DIG-1:0]   r_seg_err;
  logic               r_frame_valid;

  logic [N_DIG-1:0]   w_sel;
  logic [6:0]         w_seg;
  logic               w_onehot;
  logic               w_stable;
  logic               w_capture;
  logic [3:0]         w_nib;
  logic               w_bad;
  logic [4*N_DIG-1:0] w_slot_hex_nxt;
  logic [N_DIG-1:0]   w_slot_err_nxt;
  logic [N_DIG-1:0]   w_mask_nxt;
  logic               w_done;

  assign w_sel    = r_sync2[SW-1:7];
  assign w_seg    = r_sync2[6:0];
  assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - N_DIG'(1))) == '0);
  assign w_stable = (r_sync1 == r_sync2) && w_onehot;
  // Counter saturates one past the capture value so a held pattern is taken once.
  assign w_capture = w_onehot && (r_cnt == C_CAP);

  always_comb begin
    w_nib = 4'h0;
    w_bad = 1'b0;
    case (w_seg)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      default: begin
        w_nib = 4'h0;
        w_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_slot_hex_nxt = r_slot_hex;
    w_slot_err_nxt = r_slot_err;
    w_mask_nxt     = r_mask;
    if (w_capture) begin
      for (int i = 0; i < N_DIG; i++) begin
        if (w_sel[i]) begin
          w_slot_hex_nxt[4*i +: 4] = w_nib;
          w_slot_err_nxt[i]        = w_bad;
        end
      end
      w_mask_nxt = r_mask | w_sel;
    end
  end

  assign w_done = w_capture && (&w_mask_nxt);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_cnt         <= '0;
      r_slot_hex    <= '0;
      r_slot_err    <= '0;
      r_mask        <= '0;
      r_hex_out     <= '0;
      r_seg_err     <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_sync1 <= {DIG_SEL, SEG};
      r_sync2 <= r_sync1;
      if (!w_stable) begin
        r_cnt <= '0;
      end else if (r_cnt != C_SAT) begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_slot_hex    <= w_slot_hex_nxt;
      r_slot_err    <= w_slot_err_nxt;
      r_mask        <= w_done ? '0 : w_mask_nxt;
      r_frame_valid <= w_done;
      if (w_done) begin
        r_hex_out <= w_slot_hex_nxt;
        r_seg_err <= w_slot_err_nxt;
      end
    end
  end

  assign HEX_OUT     = r_hex_out;
  assign SEG_ERR     = r_seg_err;
  assign FRAME_VALID = r_frame_valid;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed scan scenarios plus random scanning,
// checked every cycle against a pin-history reference model.
module tb_seg7_scan_reader;

  localparam int N_DIG = 4;
  localparam int S_CYC = 4;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] hex_out;
  logic [3:0]  seg_err;
  logic        frame_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int fv_cnt  = 0;

  seg7_scan_reader #(.N_DIG(N_DIG), .STABLE_CYC(S_CYC)) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .SEG        (seg),
    .DIG_SEL    (dig_sel),
    .HEX_OUT    (hex_out),
    .SEG_ERR    (seg_err),
    .FRAME_VALID(frame_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a pin value is captured once it has been present for
  // S_CYC+1 consecutive samples, two cycles after the last of those samples.
  int          glyph [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                              'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};
  logic [10:0] hv [2];
  int          hr [2];
  logic [3:0]  m_nib [4];
  logic        m_err [4];
  logic [3:0]  m_mask;
  logic [15:0] exp_hex;
  logic [3:0]  exp_err;
  logic        exp_fv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv[0] = '0; hv[1] = '0; hr[0] = 1; hr[1] = 1;
      for (int i = 0; i < 4; i++) begin m_nib[i] = 0; m_err[i] = 0; end
      m_mask = 0; exp_hex = 0; exp_err = 0; exp_fv = 0;
    end else begin
      logic [3:0] sel;
      logic [6:0] sg;
      logic [10:0] s;
      int nib;
      exp_fv = 0;
      sel = hv[1][10:7];
      sg  = hv[1][6:0];
      if (hr[1] == S_CYC + 1 && $countones(sel) == 1) begin
        nib = -1;
        for (int g = 0; g < 16; g++) if (glyph[g] == int'(sg)) nib = g;
        for (int d = 0; d < 4; d++) begin
          if (sel[d]) begin
            m_nib[d] = (nib < 0) ? 4'h0 : nib[3:0];
            m_err[d] = (nib < 0);
            m_mask[d] = 1'b1;
          end
        end
        if (m_mask == 4'hF) begin
          for (int d = 0; d < 4; d++) begin
            exp_hex[4*d +: 4] = m_nib[d];
            exp_err[d] = m_err[d];
          end
          exp_fv = 1;
          m_mask = 0;
        end
      end
      s = {dig_sel, seg};
      hv[1] = hv[0]; hr[1] = hr[0];
      hr[0] = (s == hv[0]) ? hr[0] + 1 : 1;
      hv[0] = s;
    end
  end

  always @(negedge clk) begin
    #1;
    check_val("hex_out", 32'(hex_out), 32'(exp_hex));
    check_val("seg_err", 32'(seg_err), 32'(exp_err));
    check_val("frame_valid", 32'(frame_valid), 32'(exp_fv));
    if (frame_valid) fv_cnt++;
  end

  task automatic drive(input logic [3:0] sel, input logic [6:0] sg, input int cyc);
    dig_sel = sel;
    seg     = sg;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic pulse_reset(input int cyc);
    rst_n = 1'b0;
    repeat (cyc) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int fv0;

  initial begin
    rst_n = 1'b0; seg = 7'h7F; dig_sel = 4'b0000;
    repeat (3) @(negedge clk);
    #2;
    check_val("rst_hex", 32'(hex_out), 32'h0);
    check_val("rst_err", 32'(seg_err), 32'h0);
    check_val("rst_fv", 32'(frame_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 7'h7F, 3);

    // basic ordered scan
    fv0 = fv_cnt;
    drive(4'b0001, 7'h40, 10); drive(4'b0010, 7'h79, 10);
    drive(4'b0100, 7'h24, 10); drive(4'b1000, 7'h30, 10);
    drive(4'b0000, 7'h7F, 2);
    check_val("s1_frames", fv_cnt - fv0, 1);
    check_val("s1_hex", 32'(hex_out), 32'h3210);
    check_val("s1_err", 32'(seg_err), 32'h0);

    // long hold captures once
    fv0 = fv_cnt;
    drive(4'b0001, 7'h0E, 50);
    check_val("s2_no_frame", fv_cnt - fv0, 0);
    drive(4'b0010, 7'h79, 10); drive(4'b0100, 7'h24, 10); drive(4'b1000, 7'h30, 10);
    check_val("s2_frames", fv_cnt - fv0, 1);
    check_val("s2_hex", 32'(hex_out), 32'h321F);

    // illegal glyphs on digit 2
    drive(4'b0001, 7'h40, 10); drive(4'b0010, 7'h79, 10);
    drive(4'b0100, 7'h7F, 10); drive(4'b1000, 7'h30, 10);
    check_val("s3a_err", 32'(seg_err), 32'h4);
    check_val("s3a_hex", 32'(hex_out), 32'h3010);
    drive(4'b0100, 7'h55, 10); drive(4'b0001, 7'h40, 10);
    drive(4'b0010, 7'h79, 10); drive(4'b1000, 7'h30, 10);
    check_val("s3b_err", 32'(seg_err), 32'h4);
    check_val("s3b_hex", 32'(hex_out), 32'h3010);

    // invalid selects and toggling segments never capture
    drive(4'b0001, 7'h24, 10); drive(4'b0010, 7'h30, 10);
    drive(4'b0011, 7'h40, 20); drive(4'b0000, 7'h40, 20);
    for (int t = 0; t < 10; t++) drive(4'b0100, (t % 2) ? 7'h02 : 7'h12, 3);
    fv0 = fv_cnt;
    drive(4'b1000, 7'h00, 10);
    check_val("s4_no_frame", fv_cnt - fv0, 0);
    drive(4'b0100, 7'h10, 10);
    check_val("s4_frames", fv_cnt - fv0, 1);
    check_val("s4_hex", 32'(hex_out), 32'h8932);

    // reset discards a partial frame
    drive(4'b0001, 7'h40, 10); drive(4'b0010, 7'h79, 10); drive(4'b0100, 7'h24, 10);
    pulse_reset(1);
    fv0 = fv_cnt;
    drive(4'b1000, 7'h30, 10);
    check_val("s5_no_frame", fv_cnt - fv0, 0);
    check_val("s5_hex", 32'(hex_out), 32'h0);
    check_val("s5_err", 32'(seg_err), 32'h0);
    drive(4'b0001, 7'h40, 10); drive(4'b0010, 7'h79, 10);
    drive(4'b0100, 7'h24, 10); drive(4'b1000, 7'h30, 10);
    check_val("s5_frames", fv_cnt - fv0, 1);
    check_val("s5_hex2", 32'(hex_out), 32'h3210);

    // out-of-order scan with a repeated digit
    fv0 = fv_cnt;
    drive(4'b1000, 7'h19, 10); drive(4'b0010, 7'h79, 10); drive(4'b0010, 7'h21, 10);
    drive(4'b0001, 7'h40, 10);
    check_val("s6_no_frame", fv_cnt - fv0, 0);
    drive(4'b0100, 7'h12, 10);
    check_val("s6_frames", fv_cnt - fv0, 1);
    check_val("s6_hex", 32'(hex_out), 32'h45D0);

    // random scanning, glitches, bad selects and occasional resets
    for (int k = 0; k < 400; k++) begin
      int r;
      logic [3:0] sel;
      logic [6:0] sg;
      r = $urandom_range(0, 39);
      if (r == 0) begin
        pulse_reset($urandom_range(1, 2));
      end else begin
        if (r < 5) sel = (r % 2) ? 4'b0000 : 4'($urandom_range(3, 15) | 3);
        else       sel = 4'b0001 << $urandom_range(0, 3);
        if ($urandom_range(0, 9) < 8) sg = 7'(glyph[$urandom_range(0, 15)]);
        else                          sg = 7'($urandom);
        drive(sel, sg, $urandom_range(1, 12));
      end
    end
    drive(4'b0000, 7'h7F, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
